// File: rtl/axi_csr_seq_if.sv
// AXI4-Lite style bus bundle between the NI slave decode and the CSR sequencer.
// The master modport is the requester side; the slave modport is axi_csr_seq.
interface axi_csr_seq_if #(
    parameter int AddrWidth = 32,
    parameter int DataWidth = 32,
    parameter int IdWidth   = 4
);
    logic                   aw_valid;
    logic                   aw_ready;
    logic [AddrWidth-1:0]   aw_addr;
    logic [IdWidth-1:0]     aw_id;
    logic                   w_valid;
    logic                   w_ready;
    logic [DataWidth-1:0]   w_data;
    logic [DataWidth/8-1:0] w_strb;
    logic                   b_valid;
    logic                   b_ready;
    logic [IdWidth-1:0]     b_id;
    logic [1:0]             b_resp;
    logic                   ar_valid;
    logic                   ar_ready;
    logic [AddrWidth-1:0]   ar_addr;
    logic [IdWidth-1:0]     ar_id;
    logic                   r_valid;
    logic                   r_ready;
    logic [IdWidth-1:0]     r_id;
    logic [DataWidth-1:0]   r_data;
    logic [1:0]             r_resp;
    logic                   r_last;

    modport master (
        output aw_valid, aw_addr, aw_id, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, ar_id, r_ready,
        input  aw_ready, w_ready, b_valid, b_id, b_resp,
               ar_ready, r_valid, r_id, r_data, r_resp, r_last
    );

    modport slave (
        input  aw_valid, aw_addr, aw_id, w_valid, w_data, w_strb, b_ready,
               ar_valid, ar_addr, ar_id, r_ready,
        output aw_ready, w_ready, b_valid, b_id, b_resp,
               ar_ready, r_valid, r_id, r_data, r_resp, r_last
    );
endinterface

// File: rtl/axi_csr_seq.sv
// Sequences one AXI-Lite write or read at a time onto the single-request NI CSR port,
// with round-robin read/write arbitration and a wait-state timeout on csr_ready.
// Handshake rule: a transfer happens on a rising clk_axi edge where valid && ready;
// a valid source holds its payload stable until that edge.
module axi_csr_seq #(
    parameter int AddrWidth     = 32,
    parameter int DataWidth     = 32,
    parameter int IdWidth       = 4,
    parameter int TimeoutCycles = 16
) (
    input  logic                 clk_axi,
    input  logic                 arst_axi_n,
    axi_csr_seq_if.slave         axi,
    output logic                 csr_valid,
    output logic                 csr_rd_or_wr,
    output logic [AddrWidth-1:0] csr_addr,
    output logic [DataWidth-1:0] csr_data_in,
    input  logic                 csr_ready,
    input  logic                 csr_error,
    input  logic [DataWidth-1:0] csr_data_out,
    output logic [2:0]           state_dbg
);
    localparam int         CntW       = $clog2(TimeoutCycles + 1);
    localparam logic [1:0] RespOkay   = 2'b00;
    localparam logic [1:0] RespSlverr = 2'b10;

    typedef enum logic [2:0] {
        IDLE     = 3'd0,
        WR_ISSUE = 3'd1,
        WR_RESP  = 3'd2,
        RD_ISSUE = 3'd3,
        RD_WAIT  = 3'd4,
        RD_RESP  = 3'd5
    } state_t;

    state_t                 state_q, state_d;
    logic [CntW-1:0]        cnt_q;
    logic                   last_wr_q;
    logic [AddrWidth-1:0]   addr_q;
    logic [IdWidth-1:0]     id_q;
    logic [DataWidth-1:0]   wdata_q;
    logic [DataWidth-1:0]   rdata_q;
    logic [1:0]             resp_q;
    logic                   wr_pend, rd_pend, grant_wr, grant_rd, tmo;

    always_ff @(posedge clk_axi or negedge arst_axi_n) begin
        if (!arst_axi_n) state_q <= IDLE;
        else             state_q <= state_d;
    end

    // Conflict goes to the kind not granted last; last_wr_q only moves on a handshake.
    always_comb begin
        state_d  = state_q;
        wr_pend  = axi.aw_valid && axi.w_valid;
        rd_pend  = axi.ar_valid;
        grant_wr = wr_pend && (!rd_pend || !last_wr_q);
        grant_rd = rd_pend && !grant_wr;
        tmo      = !csr_ready && (cnt_q == CntW'(TimeoutCycles - 1));
        case (state_q)
            IDLE: begin
                if (grant_wr)      state_d = (&axi.w_strb) ? WR_ISSUE : WR_RESP;
                else if (grant_rd) state_d = RD_ISSUE;
            end
            WR_ISSUE: if (csr_ready || tmo) state_d = WR_RESP;
            RD_ISSUE: begin
                if (csr_ready) state_d = RD_WAIT;
                else if (tmo)  state_d = RD_RESP;
            end
            RD_WAIT:  state_d = RD_RESP;
            WR_RESP:  if (axi.b_ready) state_d = IDLE;
            RD_RESP:  if (axi.r_ready) state_d = IDLE;
            default:  state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk_axi or negedge arst_axi_n) begin
        if (!arst_axi_n) begin
            cnt_q     <= '0;
            last_wr_q <= 1'b0;
            addr_q    <= '0;
            id_q      <= '0;
            wdata_q   <= '0;
            rdata_q   <= '0;
            resp_q    <= RespOkay;
        end else begin
            case (state_q)
                IDLE: begin
                    if (grant_wr || grant_rd) begin
                        last_wr_q <= grant_wr;
                        cnt_q     <= '0;
                    end
                    if (grant_wr) begin
                        addr_q  <= axi.aw_addr;
                        id_q    <= axi.aw_id;
                        wdata_q <= axi.w_data;
                        // Partial strobes cannot be expressed on the CSR port.
                        resp_q  <= (&axi.w_strb) ? RespOkay : RespSlverr;
                    end else if (grant_rd) begin
                        addr_q <= axi.ar_addr;
                        id_q   <= axi.ar_id;
                    end
                end
                WR_ISSUE, RD_ISSUE: begin
                    if (csr_ready) begin
                        if (state_q == WR_ISSUE) resp_q <= csr_error ? RespSlverr : RespOkay;
                    end else if (tmo) begin
                        resp_q <= RespSlverr;
                        if (state_q == RD_ISSUE) rdata_q <= 32'hDEAD_BEEF;
                    end else begin
                        cnt_q <= cnt_q + CntW'(1);
                    end
                end
                RD_WAIT: begin
                    rdata_q <= csr_data_out;
                    resp_q  <= csr_error ? RespSlverr : RespOkay;
                end
                default: ;
            endcase
        end
    end

    assign axi.aw_ready = (state_q == IDLE) && grant_wr;
    assign axi.w_ready  = (state_q == IDLE) && grant_wr;
    assign axi.ar_ready = (state_q == IDLE) && grant_rd;

    assign axi.b_valid  = (state_q == WR_RESP);
    assign axi.b_id     = id_q;
    assign axi.b_resp   = resp_q;
    assign axi.r_valid  = (state_q == RD_RESP);
    assign axi.r_last   = (state_q == RD_RESP);
    assign axi.r_id     = id_q;
    assign axi.r_data   = rdata_q;
    assign axi.r_resp   = resp_q;

    assign csr_valid    = (state_q == WR_ISSUE) || (state_q == RD_ISSUE);
    assign csr_rd_or_wr = (state_q == WR_ISSUE);
    assign csr_addr     = csr_valid ? addr_q : '0;
    assign csr_data_in  = (state_q == WR_ISSUE) ? wdata_q : '0;
    assign state_dbg    = state_q;
endmodule

// File: tb/tb_axi_csr_seq.sv
// Directed bench for axi_csr_seq: one task per scenario, cycle-exact checks against
// hand-computed expectations, expected grant order held in a queue.
module tb_axi_csr_seq;
  localparam int AW = 32;
  localparam int DW = 32;
  localparam int IW = 4;
  localparam logic [2:0] S_IDLE = 3'd0, S_WR_RESP = 3'd2, S_RD_WAIT = 3'd4, S_RD_RESP = 3'd5;

  logic          clk_axi = 1'b0;
  logic          arst_axi_n;
  logic          csr_valid, csr_rd_or_wr, csr_ready, csr_error;
  logic [AW-1:0] csr_addr;
  logic [DW-1:0] csr_data_in, csr_data_out;
  logic [2:0]    state_dbg;

  int errors = 0;
  int checks = 0;
  logic [DW-1:0] exp_q[$];

  axi_csr_seq_if #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW)) axi ();

  axi_csr_seq #(.AddrWidth(AW), .DataWidth(DW), .IdWidth(IW), .TimeoutCycles(16)) dut (
    .clk_axi(clk_axi), .arst_axi_n(arst_axi_n), .axi(axi),
    .csr_valid(csr_valid), .csr_rd_or_wr(csr_rd_or_wr), .csr_addr(csr_addr),
    .csr_data_in(csr_data_in), .csr_ready(csr_ready), .csr_error(csr_error),
    .csr_data_out(csr_data_out), .state_dbg(state_dbg)
  );

  // clock / reset
  always #5 clk_axi = ~clk_axi;

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // driver tasks
  task automatic tick();
    @(posedge clk_axi);
    #1;
  endtask

  task automatic idle_inputs();
    axi.aw_valid = 0; axi.aw_addr = '0; axi.aw_id = '0;
    axi.w_valid = 0; axi.w_data = '0; axi.w_strb = '0; axi.b_ready = 0;
    axi.ar_valid = 0; axi.ar_addr = '0; axi.ar_id = '0; axi.r_ready = 0;
    csr_ready = 0; csr_error = 0; csr_data_out = '0;
  endtask

  task automatic test_reset();
    arst_axi_n = 1'b0;
    idle_inputs();
    repeat (3) tick();
    checks++;
    if ({axi.aw_ready, axi.w_ready, axi.ar_ready, axi.b_valid, axi.r_valid, axi.r_last,
         csr_valid, csr_rd_or_wr} !== 8'h00) begin
      errors++; $display("FAIL reset_flags got %b required 00000000",
        {axi.aw_ready, axi.w_ready, axi.ar_ready, axi.b_valid, axi.r_valid, axi.r_last, csr_valid, csr_rd_or_wr});
    end
    checks++;
    if ({axi.b_resp, axi.r_resp, axi.b_id, axi.r_id} !== 12'h000) begin
      errors++; $display("FAIL reset_resp_id got %h required 000", {axi.b_resp, axi.r_resp, axi.b_id, axi.r_id});
    end
    checks++;
    if ({axi.r_data, csr_addr, csr_data_in} !== 96'h0) begin
      errors++; $display("FAIL reset_data got %h required 0", {axi.r_data, csr_addr, csr_data_in});
    end
    checks++;
    if (state_dbg !== S_IDLE) begin errors++; $display("FAIL reset_state got %0d required 0", state_dbg); end
    arst_axi_n = 1'b1;
    tick();
  endtask

  task automatic test_single_write();
    axi.aw_valid = 1; axi.aw_addr = 32'h08; axi.aw_id = 4'h5;
    axi.w_valid = 1; axi.w_data = 32'h3; axi.w_strb = 4'hF; csr_ready = 1;
    #1;
    checks++;
    if ({axi.aw_ready, axi.w_ready, axi.ar_ready} !== 3'b110) begin
      errors++; $display("FAIL wr_ready got %b required 110", {axi.aw_ready, axi.w_ready, axi.ar_ready});
    end
    tick();
    axi.aw_valid = 0; axi.w_valid = 0;
    checks++;
    if ({csr_valid, csr_rd_or_wr, axi.b_valid} !== 3'b110) begin
      errors++; $display("FAIL wr_issue_flags got %b required 110", {csr_valid, csr_rd_or_wr, axi.b_valid});
    end
    checks++;
    if ({csr_addr, csr_data_in} !== {32'h8, 32'h3}) begin
      errors++; $display("FAIL wr_issue_payload got %h required %h", {csr_addr, csr_data_in}, {32'h8, 32'h3});
    end
    tick();
    checks++;
    if ({csr_valid, axi.b_valid, axi.b_resp, axi.b_id} !== {1'b0, 1'b1, 2'b00, 4'h5}) begin
      errors++; $display("FAIL wr_bresp got %b required 0100101", {csr_valid, axi.b_valid, axi.b_resp, axi.b_id});
    end
    tick();
    checks++;
    if ({axi.b_valid, axi.b_id} !== {1'b1, 4'h5}) begin
      errors++; $display("FAIL wr_b_hold got %b required 10101", {axi.b_valid, axi.b_id});
    end
    axi.b_ready = 1;
    tick();
    axi.b_ready = 0;
    checks++;
    if ({axi.b_valid, state_dbg} !== {1'b0, S_IDLE}) begin
      errors++; $display("FAIL wr_b_done got %b required 0000", {axi.b_valid, state_dbg});
    end
  endtask

  task automatic test_single_read();
    axi.ar_valid = 1; axi.ar_addr = 32'h0; axi.ar_id = 4'h3; csr_ready = 1;
    #1;
    checks++;
    if ({axi.aw_ready, axi.ar_ready} !== 2'b01) begin
      errors++; $display("FAIL rd_ready got %b required 01", {axi.aw_ready, axi.ar_ready});
    end
    tick();
    axi.ar_valid = 0;
    checks++;
    if ({csr_valid, csr_rd_or_wr, csr_addr} !== {1'b1, 1'b0, 32'h0}) begin
      errors++; $display("FAIL rd_issue got %h required %h", {csr_valid, csr_rd_or_wr, csr_addr}, {1'b1, 1'b0, 32'h0});
    end
    tick();
    csr_data_out = 32'hCAFE0001; csr_error = 0;
    checks++;
    if ({state_dbg, csr_valid, axi.r_valid} !== {S_RD_WAIT, 2'b00}) begin
      errors++; $display("FAIL rd_wait got %b required 10000", {state_dbg, csr_valid, axi.r_valid});
    end
    tick();
    csr_data_out = 32'h0;
    checks++;
    if ({axi.r_valid, axi.r_last, axi.r_resp, axi.r_id} !== {1'b1, 1'b1, 2'b00, 4'h3}) begin
      errors++; $display("FAIL rd_rresp got %b required 11000011", {axi.r_valid, axi.r_last, axi.r_resp, axi.r_id});
    end
    checks++;
    if (axi.r_data !== 32'hCAFE0001) begin
      errors++; $display("FAIL rd_rdata got %h required cafe0001", axi.r_data);
    end
    axi.r_ready = 1;
    tick();
    axi.r_ready = 0;
    checks++;
    if (axi.r_valid !== 1'b0) begin errors++; $display("FAIL rd_done got %b required 0", axi.r_valid); end
  endtask

  task automatic test_errors();
    axi.aw_valid = 1; axi.aw_addr = 32'h10; axi.aw_id = 4'h2;
    axi.w_valid = 1; axi.w_data = 32'h55; axi.w_strb = 4'hF;
    tick();
    axi.aw_valid = 0; axi.w_valid = 0; csr_ready = 1; csr_error = 1;
    tick();
    csr_error = 0;
    checks++;
    if ({axi.b_valid, axi.b_resp, axi.b_id} !== {1'b1, 2'b10, 4'h2}) begin
      errors++; $display("FAIL err_wr got %b required 1100010", {axi.b_valid, axi.b_resp, axi.b_id});
    end
    axi.b_ready = 1;
    tick();
    axi.b_ready = 0;
    axi.ar_valid = 1; axi.ar_addr = 32'h44; axi.ar_id = 4'h7;
    tick();
    axi.ar_valid = 0; csr_ready = 1; csr_error = 0;
    tick();
    csr_error = 1; csr_data_out = 32'h0;
    tick();
    csr_error = 0;
    checks++;
    if ({axi.r_valid, axi.r_resp, axi.r_id} !== {1'b1, 2'b10, 4'h7}) begin
      errors++; $display("FAIL err_rd got %b required 1100111", {axi.r_valid, axi.r_resp, axi.r_id});
    end
    axi.r_ready = 1;
    tick();
    axi.r_ready = 0;
  endtask

  task automatic test_back_to_back();
    int cyc, last_cyc, guard;
    logic last_w;
    logic [DW-1:0] exp;
    cyc = 0; last_cyc = 0; last_w = 0;
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    exp_q.push_back(32'd1); exp_q.push_back(32'd0);
    axi.aw_valid = 1; axi.w_valid = 1; axi.w_strb = 4'hF; axi.aw_addr = 32'h0C; axi.w_data = 32'h77;
    axi.ar_valid = 1; axi.ar_addr = 32'h04;
    axi.b_ready = 1; axi.r_ready = 1; csr_ready = 1; csr_error = 0;
    #1;
    for (int n = 0; n < 4; n++) begin
      guard = 0;
      while (!(axi.aw_ready || axi.ar_ready) && guard < 20) begin
        tick(); cyc++; guard++;
      end
      checks++;
      if (!(axi.aw_ready || axi.ar_ready)) begin
        errors++; $display("FAIL b2b_grant_timeout n=%0d got no ready required a grant", n);
      end
      exp = exp_q.pop_front();
      checks++;
      if (DW'(axi.aw_ready) !== exp) begin
        errors++; $display("FAIL b2b_order n=%0d got wr=%0d required wr=%0d", n, axi.aw_ready, exp);
      end
      checks++;
      if (axi.aw_ready && axi.ar_ready) begin
        errors++; $display("FAIL b2b_overlap n=%0d got both ready required one", n);
      end
      if (n > 0) begin
        checks++;
        if (cyc - last_cyc !== (last_w ? 3 : 4)) begin
          errors++; $display("FAIL b2b_spacing n=%0d got %0d required %0d", n, cyc - last_cyc, last_w ? 3 : 4);
        end
      end
      last_w = axi.aw_ready;
      last_cyc = cyc;
      tick(); cyc++;
    end
    axi.aw_valid = 0; axi.w_valid = 0; axi.ar_valid = 0;
    guard = 0;
    while (state_dbg !== S_IDLE && guard < 20) begin tick(); guard++; end
    axi.b_ready = 0; axi.r_ready = 0;
    checks++;
    if (state_dbg !== S_IDLE) begin errors++; $display("FAIL b2b_drain got %0d required 0", state_dbg); end
  endtask

  task automatic test_timeout();
    int n;
    axi.ar_valid = 1; axi.ar_addr = 32'h20; axi.ar_id = 4'h9; csr_ready = 0;
    tick();
    axi.ar_valid = 0;
    n = 0;
    while (csr_valid && n < 40) begin n++; tick(); end
    checks++;
    if (n !== 16) begin errors++; $display("FAIL tmo_rd_cycles got %0d required 16", n); end
    checks++;
    if ({axi.r_valid, axi.r_resp, axi.r_data} !== {1'b1, 2'b10, 32'hDEADBEEF}) begin
      errors++; $display("FAIL tmo_rd_resp got %h required %h", {axi.r_valid, axi.r_resp, axi.r_data}, {1'b1, 2'b10, 32'hDEADBEEF});
    end
    axi.r_ready = 1;
    tick();
    axi.r_ready = 0;
    axi.aw_valid = 1; axi.w_valid = 1; axi.aw_addr = 32'h24; axi.aw_id = 4'hA; axi.w_strb = 4'hF;
    tick();
    axi.aw_valid = 0; axi.w_valid = 0;
    n = 0;
    while (csr_valid && n < 40) begin n++; tick(); end
    checks++;
    if ({n[7:0], axi.b_valid, axi.b_resp} !== {8'd16, 1'b1, 2'b10}) begin
      errors++; $display("FAIL tmo_wr got n=%0d b_valid=%b b_resp=%b required 16 1 10", n, axi.b_valid, axi.b_resp);
    end
    axi.b_ready = 1;
    tick();
    axi.b_ready = 0;
  endtask

  task automatic test_bad_strb();
    axi.aw_valid = 1; axi.w_valid = 1; axi.aw_addr = 32'h08; axi.aw_id = 4'h6;
    axi.w_data = 32'h1; axi.w_strb = 4'h3; csr_ready = 1;
    #1;
    checks++;
    if (axi.aw_ready !== 1'b1) begin errors++; $display("FAIL strb_ready got %b required 1", axi.aw_ready); end
    tick();
    axi.aw_valid = 0; axi.w_valid = 0;
    checks++;
    if ({csr_valid, state_dbg, axi.b_valid, axi.b_resp, axi.b_id} !== {1'b0, S_WR_RESP, 1'b1, 2'b10, 4'h6}) begin
      errors++; $display("FAIL strb_resp got %b required 00101100110",
        {csr_valid, state_dbg, axi.b_valid, axi.b_resp, axi.b_id});
    end
    axi.b_ready = 1;
    tick();
    axi.b_ready = 0;
  endtask

  task automatic test_reset_mid();
    axi.ar_valid = 1; axi.ar_addr = 32'h30; axi.ar_id = 4'h4; csr_ready = 0;
    tick();
    axi.ar_valid = 0;
    #2 arst_axi_n = 0;
    #1;
    checks++;
    if ({csr_valid, state_dbg} !== {1'b0, S_IDLE}) begin
      errors++; $display("FAIL rst_issue got %b required 0000", {csr_valid, state_dbg});
    end
    tick();
    arst_axi_n = 1;
    axi.ar_valid = 1; axi.ar_addr = 32'h4; axi.ar_id = 4'h1; csr_ready = 1;
    tick();
    axi.ar_valid = 0;
    tick();
    csr_data_out = 32'h1234_5678;
    checks++;
    if (state_dbg !== S_RD_WAIT) begin errors++; $display("FAIL rst_reach_wait got %0d required 4", state_dbg); end
    #2 arst_axi_n = 0;
    #1;
    checks++;
    if ({state_dbg, csr_valid, axi.r_valid, axi.r_last, axi.r_id, axi.r_resp, axi.r_data} !== 43'h0) begin
      errors++; $display("FAIL rst_wait got %h required 0",
        {state_dbg, csr_valid, axi.r_valid, axi.r_last, axi.r_id, axi.r_resp, axi.r_data});
    end
    tick();
    arst_axi_n = 1;
    tick();
    checks++;
    if ({state_dbg, axi.r_valid} !== {S_IDLE, 1'b0}) begin
      errors++; $display("FAIL rst_discard got %b required 0000", {state_dbg, axi.r_valid});
    end
    axi.ar_valid = 1; axi.ar_addr = 32'h4; axi.ar_id = 4'h1;
    tick();
    axi.ar_valid = 0;
    tick();
    csr_data_out = 32'hA5A5_0002;
    tick();
    checks++;
    if ({state_dbg, axi.r_valid, axi.r_resp, axi.r_id, axi.r_data} !== {S_RD_RESP, 1'b1, 2'b00, 4'h1, 32'hA5A5_0002}) begin
      errors++; $display("FAIL rst_next_read got %h required %h",
        {state_dbg, axi.r_valid, axi.r_resp, axi.r_id, axi.r_data}, {S_RD_RESP, 1'b1, 2'b00, 4'h1, 32'hA5A5_0002});
    end
    axi.r_ready = 1;
    tick();
    axi.r_ready = 0;
  endtask

  // scenario sequence and final report
  initial begin
    test_reset();
    test_single_write();
    test_single_read();
    test_errors();
    test_back_to_back();
    test_timeout();
    test_bad_strb();
    test_reset_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
